pipelined_adder: RTL and testbench

//   Next-generation registered adder for the overclocking test platform.

---
 rtl/adder_pkg.sv | 27 ++
 rtl/adder_seg.sv | 46 ++++
 rtl/pipelined_adder.sv | 146 ++++++++++++++
 tb/tb_pipelined_adder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the segmented carry-chain adder: segment sizing,
// saturation limits and handshake state names.
package adder_pkg;

    localparam int MAX_WL = 64;
    localparam logic [MAX_WL-1:0] SAT_POS_ALL = {1'b0, {(MAX_WL-1){1'b1}}};
    localparam logic [MAX_WL-1:0] SAT_NEG_ALL = {1'b1, {(MAX_WL-1){1'b0}}};

    typedef enum logic [1:0] {
        HS_IDLE,
        HS_BUSY,
        HS_STALL
    } hs_state_e;

    function automatic int seg_w(int wl, int nseg);
        return (wl + nseg - 1) / nseg;
    endfunction

    // Width of segment k; zero when ceil-sizing leaves no bits for it.
    function automatic int seg_width(int wl, int nseg, int k);
        int lo;
        lo = k * seg_w(wl, nseg);
        if (lo >= wl) return 0;
        return (wl - lo < seg_w(wl, nseg)) ? wl - lo : seg_w(wl, nseg);
    endfunction

endpackage

// File: rtl/adder_seg.sv
// One registered slice of the carry chain: W-bit sum, carry out and valid,
// advancing only on adv_i and cleared synchronously by flush_i.
module adder_seg #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         adv_i,
    input  logic         flush_i,
    input  logic         vld_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o,
    output logic         vld_o
);

    logic [W:0]   total_d;
    logic [W-1:0] sum_q;
    logic         cout_q;
    logic         vld_q;

    assign total_d = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            vld_q  <= 1'b0;
        end else if (flush_i) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            vld_q  <= 1'b0;
        end else if (adv_i) begin
            sum_q  <= total_d[W-1:0];
            cout_q <= total_d[W];
            vld_q  <= vld_i;
        end
    end

    assign sum_o  = sum_q;
    assign cout_o = cout_q;
    assign vld_o  = vld_q;

endmodule

// File: rtl/pipelined_adder.sv
// WL-bit add/sub whose carry chain is cut into NSEG registered segments, with
// operand skew, result deskew, overflow/saturation and a stalling stream port.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WL   = 8,
    parameter int NSEG = 2,
    parameter int SAT  = 0
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          enable,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [WL-1:0] din_x,
    input  logic [WL-1:0] din_y,
    input  logic          sub,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [WL-1:0] data_out,
    output logic          carry_out,
    output logic          ovf
);

    localparam int SW = seg_w(WL, NSEG);
    localparam logic [WL-1:0] SMAX = SAT_POS_ALL[MAX_WL-1 -: WL];
    localparam logic [WL-1:0] SMIN = SAT_NEG_ALL[MAX_WL-1 -: WL];

    hs_state_e       hs_st;
    logic            adv;
    logic            flush;
    logic            accept;
    logic [WL-1:0]   xw     [NSEG];
    logic [WL-1:0]   yw     [NSEG];
    logic [WL-1:0]   lo_w   [NSEG];
    logic [WL-1:0]   part_w [NSEG];
    logic [NSEG-1:0] c_w;
    logic [NSEG-1:0] v_w;
    logic            xm_q;
    logic            ym_q;
    logic [WL-1:0]   sum_raw;

    function automatic logic [WL-1:0] saturate(input logic [WL-1:0] raw,
                                               input logic of, input logic neg);
        if (SAT == 0 || !of) return raw;
        return neg ? SMIN : SMAX;
    endfunction

    always_comb begin
        hs_st = HS_BUSY;
        if (!out_valid)      hs_st = HS_IDLE;
        else if (!out_ready) hs_st = HS_STALL;
    end

    assign adv      = (hs_st != HS_STALL);
    assign flush    = !enable;
    assign in_ready = adv & enable & nrst;
    assign accept   = in_valid & in_ready;

    assign xw[0]   = din_x;
    assign yw[0]   = din_y ^ {WL{sub}};
    assign lo_w[0] = '0;

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        localparam int LO = k * SW;
        localparam int W  = seg_width(WL, NSEG, k);
        logic cin;
        logic vin;

        if (k == 0) begin : g_first
            assign cin = sub;
            assign vin = accept;
        end else begin : g_next
            assign cin = c_w[k-1];
            assign vin = v_w[k-1];
        end

        if (W > 0) begin : g_real
            logic [W-1:0] s;
            logic         co;
            adder_seg #(.W(W)) u_seg (
                .clk(clk), .nrst(nrst), .adv_i(adv), .flush_i(flush), .vld_i(vin),
                .a_i(xw[k][LO +: W]), .b_i(yw[k][LO +: W]), .cin_i(cin),
                .sum_o(s), .cout_o(co), .vld_o(v_w[k])
            );
            assign c_w[k]    = co;
            assign part_w[k] = WL'(s) << LO;
        end else begin : g_pass
            // Empty slice: 0 + 0 + cin leaves the incoming carry in the sum bit.
            logic s;
            logic co;
            adder_seg #(.W(1)) u_seg (
                .clk(clk), .nrst(nrst), .adv_i(adv), .flush_i(flush), .vld_i(vin),
                .a_i(1'b0), .b_i(1'b0), .cin_i(cin),
                .sum_o(s), .cout_o(co), .vld_o(v_w[k])
            );
            assign c_w[k]    = s | co;
            assign part_w[k] = '0;
        end

        if (k > 0) begin : g_skew
            logic [WL-1:0] x_q;
            logic [WL-1:0] y_q;
            logic [WL-1:0] lo_q;
            always_ff @(posedge clk or negedge nrst) begin
                if (!nrst) begin
                    x_q  <= '0;
                    y_q  <= '0;
                    lo_q <= '0;
                end else if (flush) begin
                    x_q  <= '0;
                    y_q  <= '0;
                    lo_q <= '0;
                end else if (adv) begin
                    x_q  <= xw[k-1];
                    y_q  <= yw[k-1];
                    lo_q <= lo_w[k-1] | part_w[k-1];
                end
            end
            assign xw[k]   = x_q;
            assign yw[k]   = y_q;
            assign lo_w[k] = lo_q;
        end
    end

    // Operand sign bits travel with the last slice so the flags line up with it.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            xm_q <= 1'b0;
            ym_q <= 1'b0;
        end else if (flush) begin
            xm_q <= 1'b0;
            ym_q <= 1'b0;
        end else if (adv) begin
            xm_q <= xw[NSEG-1][WL-1];
            ym_q <= yw[NSEG-1][WL-1];
        end
    end

    assign sum_raw   = lo_w[NSEG-1] | part_w[NSEG-1];
    assign ovf       = (xm_q == ym_q) && (sum_raw[WL-1] != xm_q);
    assign carry_out = c_w[NSEG-1];
    assign out_valid = v_w[NSEG-1];
    assign data_out  = saturate(sum_raw, ovf, xm_q);

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench: four adder configurations run in parallel, each with
// directed corner cases, stall, flush, reset and random backpressured traffic.
module tb_pipelined_adder;

    localparam int NOPS = 10000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;

    typedef struct {
        longint d;
        bit     c;
        bit     o;
        int     acc;
        bit     seen;
    } exp_t;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on signed/unsigned interpretations.
    function automatic exp_t model(input int wl, input int sat, input longint x,
                                   input longint y, input bit s);
        exp_t   e;
        longint m, half, sx, sy, sr;
        m    = (longint'(1) << wl) - 1;
        half = longint'(1) << (wl - 1);
        sx   = (x >= half) ? x - (m + 1) : x;
        sy   = (y >= half) ? y - (m + 1) : y;
        sr   = s ? sx - sy : sx + sy;
        e.d  = (s ? x - y : x + y) & m;
        e.c  = s ? (x >= y) : ((x + y) > m);
        e.o  = (sr >= half) || (sr < -half);
        if (sat != 0 && e.o) e.d = (sx < 0) ? half : half - 1;
        e.acc  = 0;
        e.seen = 1'b0;
        return e;
    endfunction

    for (genvar c = 0; c < 4; c++) begin : g_cfg
        localparam int     W   = (c >= 2) ? 13 : 8;
        localparam int     NS  = (c == 2) ? 4 : ((c == 3) ? 1 : 2);
        localparam int     SA  = (c == 1) ? 1 : 0;
        localparam longint M   = (longint'(1) << W) - 1;
        localparam longint SMX = (longint'(1) << (W - 1)) - 1;
        localparam longint SMN = longint'(1) << (W - 1);

        logic         rstn, en, iv, irdy, dsub, ov, co, of;
        logic         ordy = 1'b1;
        logic [W-1:0] dx, dy, dout;
        int           mode   = 0;
        int           advcnt = 0;
        bit           adv_n  = 1'b1;
        exp_t         q[$];

        pipelined_adder #(.WL(W), .NSEG(NS), .SAT(SA)) dut (
            .clk(clk), .nrst(rstn), .enable(en), .in_valid(iv), .in_ready(irdy),
            .din_x(dx), .din_y(dy), .sub(dsub), .out_valid(ov), .out_ready(ordy),
            .data_out(dout), .carry_out(co), .ovf(of)
        );

        always @(posedge clk) begin
            #2;
            ordy = (mode == 0) ? 1'b1 : ((mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b0);
        end

        always @(posedge clk) advcnt <= advcnt + int'(adv_n);

        always @(negedge clk) begin : mon
            bit adv_e;
            adv_e = !ov || ordy;
            chk($sformatf("cfg%0d in_ready", c), irdy, adv_e && en && rstn);
            if (ov) begin
                if (q.size() == 0) begin
                    chk($sformatf("cfg%0d spurious_out_valid", c), ov, 0);
                end else begin
                    chk($sformatf("cfg%0d data_out", c), dout, q[0].d);
                    chk($sformatf("cfg%0d carry_out", c), co, q[0].c);
                    chk($sformatf("cfg%0d ovf", c), of, q[0].o);
                    if (!q[0].seen)
                        chk($sformatf("cfg%0d latency", c), advcnt - q[0].acc, NS);
                    q[0].seen = 1'b1;
                    if (ordy) void'(q.pop_front());
                end
            end
            adv_n = adv_e;
        end

        function automatic longint rnd();
            return longint'($urandom) & M;
        endfunction

        task automatic send(input longint x, input longint y, input bit s);
            bit   got;
            exp_t e;
            got  = 1'b0;
            dx   = W'(x);
            dy   = W'(y);
            dsub = s;
            iv   = 1'b1;
            for (int i = 0; i < 500 && !got; i++) begin
                @(negedge clk);
                if (irdy) begin
                    e     = model(W, SA, x, y, s);
                    e.acc = advcnt;
                    q.push_back(e);
                    got = 1'b1;
                end
            end
            if (!got) chk($sformatf("cfg%0d accept_timeout", c), irdy, 1);
            @(posedge clk);
            #1;
        endtask

        task automatic idle(input int n);
            iv = 1'b0;
            repeat (n) @(posedge clk);
            #1;
        endtask

        task automatic chk_zero(input string tag);
            chk($sformatf("cfg%0d %s out_valid", c, tag), ov, 0);
            chk($sformatf("cfg%0d %s data_out", c, tag), dout, 0);
            chk($sformatf("cfg%0d %s carry_out", c, tag), co, 0);
            chk($sformatf("cfg%0d %s ovf", c, tag), of, 0);
            chk($sformatf("cfg%0d %s in_ready", c, tag), irdy, 0);
        endtask

        initial begin
            rstn = 1'b0; en = 1'b1; iv = 1'b0; dsub = 1'b0; dx = '0; dy = '0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            chk_zero("reset");
            @(posedge clk);
            #1 rstn = 1'b1;

            send(SMX, 1, 0);
            send(SMN, M, 0);
            send(0, 1, 1);
            send(5, 3, 1);
            send(SMN, 1, 1);
            send(SMX, M, 1);
            idle(8);

            fork
                begin
                    for (int i = 0; i < 4; i++) send(rnd(), rnd(), $urandom_range(0, 1) == 1);
                    iv = 1'b0;
                end
                begin
                    repeat (NS) @(posedge clk);
                    #1 mode = 2;
                    repeat (3) @(posedge clk);
                    #1 mode = 0;
                end
            join
            idle(8);

            send(rnd(), rnd(), 0);
            send(rnd(), rnd(), 1);
            iv = 1'b0;
            en = 1'b0;
            @(negedge clk);
            @(posedge clk);
            #1 q.delete();
            @(negedge clk);
            chk_zero("flush");
            @(posedge clk);
            #1 en = 1'b1;
            send(rnd(), rnd(), 1);
            idle(8);

            send(3, 4, 0);
            iv = 1'b0;
            #2 rstn = 1'b0;
            #1 chk_zero("async_reset");
            q.delete();
            @(posedge clk);
            #1 rstn = 1'b1;
            idle(2);

            mode = 1;
            for (int i = 0; i < NOPS; i++) begin
                if ($urandom_range(0, 3) == 0) idle(1);
                send(rnd(), rnd(), $urandom_range(0, 1) == 1);
            end
            iv = 1'b0;
            mode = 0;
            for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
            chk($sformatf("cfg%0d drain", c), q.size(), 0);
            done_cnt++;
        end
    end

    initial begin
        for (int i = 0; i < 90000 && done_cnt < 4; i++) @(posedge clk);
        chk("all_configs_done", done_cnt, 4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
